// File: rtl/matmul_result_drain_if.sv
// Port bundle for the result drain: row intake from the systolic array,
// element stream to writeback, plus the control/status pins.
interface matmul_result_drain_if #(
    parameter int N     = 4,
    parameter int ACC_W = 16
);
    logic               start;
    logic               abort;
    logic               res_valid;
    logic [N*ACC_W-1:0] res_data;
    logic               res_ready;
    logic               out_valid;
    logic [ACC_W-1:0]   out_data;
    logic               out_last;
    logic               out_ready;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, res_valid, res_data, out_ready,
        input  res_ready, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  start, abort, res_valid, res_data, out_ready,
        output res_ready, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/matmul_result_drain.sv
// Buffers one N x N accumulator tile row by row, then streams it out
// row-major, one element per accepted beat.
module matmul_result_drain #(
    parameter int N     = 4,
    parameter int ACC_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    matmul_result_drain_if.slave  bus,
    output logic [1:0]            dbg_state
);
    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   row_cnt_q, row_cnt_d;
    logic [CW-1:0]   col_cnt_q, col_cnt_d;
    logic [ACC_W-1:0] tile_q [N][N];
    logic [ACC_W-1:0] tile_d [N][N];
    logic            row_xfer;

    // Both streams use plain valid/ready: a beat moves on a rising edge
    // where valid && ready; the producer must hold its payload until then.
    always_comb begin
        state_d       = state_q;
        row_cnt_d     = row_cnt_q;
        col_cnt_d     = col_cnt_q;
        row_xfer      = 1'b0;
        bus.res_ready = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        bus.busy      = (state_q != IDLE);
        bus.done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = CAPTURE;
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                end
            end
            CAPTURE: begin
                bus.res_ready = 1'b1;
                row_xfer      = bus.res_valid;
                if (row_xfer) begin
                    if (row_cnt_q == LAST) begin
                        state_d   = DRAIN;
                        row_cnt_d = '0;
                        col_cnt_d = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                bus.out_valid = 1'b1;
                bus.out_data  = tile_q[row_cnt_q][col_cnt_q];
                bus.out_last  = (row_cnt_q == LAST) && (col_cnt_q == LAST);
                if (bus.out_ready) begin
                    if (col_cnt_q == LAST) begin
                        col_cnt_d = '0;
                        if (row_cnt_q == LAST) begin
                            state_d   = DONE;
                            row_cnt_d = '0;
                        end else begin
                            row_cnt_d = row_cnt_q + 1'b1;
                        end
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a start seen in IDLE.
        if (bus.abort) begin
            state_d   = IDLE;
            row_cnt_d = '0;
            col_cnt_d = '0;
            row_xfer  = 1'b0;
        end
    end

    always_comb begin
        tile_d = tile_q;
        for (int r = 0; r < N; r++) begin
            if (row_xfer && (row_cnt_q == CW'(r))) begin
                for (int c = 0; c < N; c++) begin
                    tile_d[r][c] = bus.res_data[c*ACC_W +: ACC_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
        end
    end

    // Tile storage carries no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        tile_q <= tile_d;
    end

    assign dbg_state = state_q;
endmodule

// File: tb/tb_matmul_result_drain.sv
// Directed bench for matmul_result_drain at N=2, ACC_W=16: a cycle table for
// the basic tile, then hand-written sequences for stalls, gaps, abort and reset.
module tb_matmul_result_drain;
    localparam int N     = 2;
    localparam int ACC_W = 16;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    matmul_result_drain_if #(.N(N), .ACC_W(ACC_W)) bus ();

    matmul_result_drain #(.N(N), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    logic [ACC_W-1:0] exp_q[$];

    typedef struct {
        logic        start;
        logic        res_valid;
        logic [31:0] res_data;
        logic        out_ready;
        logic        exp_res_ready;
        logic        exp_out_valid;
        logic [15:0] exp_out_data;
        logic        exp_out_last;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_tile(input logic [31:0] r0, input logic [31:0] r1);
        exp_q.push_back(r0[15:0]);
        exp_q.push_back(r0[31:16]);
        exp_q.push_back(r1[15:0]);
        exp_q.push_back(r1[31:16]);
    endtask

    task automatic start_tile();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Feeds two rows, one every gap cycles; returns at the negedge after the last row.
    task automatic capture(input logic [31:0] r0, input logic [31:0] r1, input int gap);
        int k = 0;
        int cyc = 0;
        while (k < 2 && cyc < 40) begin
            check("cap_res_ready", 32'(bus.res_ready), 32'd1);
            check("cap_no_drain", 32'(bus.out_valid), 32'd0);
            if ((cyc % gap) == (gap - 1)) begin
                bus.res_valid = 1'b1;
                bus.res_data  = (k == 0) ? r0 : r1;
                k++;
            end else begin
                bus.res_valid = 1'b0;
                bus.res_data  = 32'h0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.res_valid = 1'b0;
        bus.res_data  = 32'h0;
        check("cap_rows", 32'(k), 32'd2);
        check("cap_ready_drop", 32'(bus.res_ready), 32'd0);
        check("cap_drain_start", 32'(bus.out_valid), 32'd1);
    endtask

    // Drains exp_q with a ready pattern; optionally aborts after a number of transfers.
    task automatic drain(input bit [15:0] pat, input int plen, input int abort_after,
                         input bit poke_start, input int n_exp);
        int vcyc = 0;
        int xfers = 0;
        int budget = 0;
        bit aborted = 1'b0;
        logic rdy;
        while (exp_q.size() > 0 && budget < 50) begin
            if (abort_after >= 0 && xfers == abort_after) begin
                bus.abort     = 1'b1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                bus.abort = 1'b0;
                check("abort_valid", 32'(bus.out_valid), 32'd0);
                check("abort_busy", 32'(bus.busy), 32'd0);
                check("abort_done", 32'(bus.done), 32'd0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("abort_no_done", 32'(bus.done), 32'd0);
                end
                exp_q.delete();
                aborted = 1'b1;
                break;
            end
            check("drain_valid", 32'(bus.out_valid), 32'd1);
            if (bus.out_valid) begin
                check("drain_data", 32'(bus.out_data), 32'(exp_q[0]));
                check("drain_last", 32'(bus.out_last), 32'(exp_q.size() == 1));
                rdy = (vcyc < plen) ? pat[vcyc] : 1'b1;
                bus.out_ready = rdy;
                bus.start     = poke_start && (vcyc == 1);
                if (rdy) begin
                    void'(exp_q.pop_front());
                    xfers++;
                end
                vcyc++;
            end
            @(negedge clk);
            bus.start = 1'b0;
            budget++;
        end
        bus.out_ready = 1'b0;
        if (!aborted) begin
            check("drain_complete", 32'(exp_q.size()), 32'd0);
            check("drain_xfers", 32'(xfers), 32'(n_exp));
            check("done_pulse", 32'(bus.done), 32'd1);
            check("done_busy", 32'(bus.busy), 32'd1);
            check("done_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
            check("post_done", 32'(bus.done), 32'd0);
            check("post_busy", 32'(bus.busy), 32'd0);
            check("post_state", 32'(dbg_state), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0002_0001, 1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h0004_0003, 1'b1, 1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0};

        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = 32'h0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_res_ready", 32'(bus.res_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b1;

        // Basic tile, cycle by cycle.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("vec_res_ready", 32'(bus.res_ready), 32'(vecs[i].exp_res_ready));
            check("vec_out_valid", 32'(bus.out_valid), 32'(vecs[i].exp_out_valid));
            check("vec_out_data", 32'(bus.out_data), 32'(vecs[i].exp_out_data));
            check("vec_out_last", 32'(bus.out_last), 32'(vecs[i].exp_out_last));
            check("vec_busy", 32'(bus.busy), 32'(vecs[i].exp_busy));
            check("vec_done", 32'(bus.done), 32'(vecs[i].exp_done));
            bus.start     = vecs[i].start;
            bus.res_valid = vecs[i].res_valid;
            bus.res_data  = vecs[i].res_data;
            bus.out_ready = vecs[i].out_ready;
        end

        // Backpressure: ready pattern 1,0,0,1,0,1,1.
        start_tile();
        capture(32'h0002_0001, 32'h0004_0003, 1);
        push_tile(32'h0002_0001, 32'h0004_0003);
        drain(16'h0069, 7, -1, 1'b0, 4);

        // Gapped capture: a row every third cycle.
        start_tile();
        capture(32'h0006_0005, 32'h0008_0007, 3);
        push_tile(32'h0006_0005, 32'h0008_0007);
        drain(16'hffff, 0, -1, 1'b0, 4);

        // Spurious row in IDLE, then a stray start during DRAIN.
        @(negedge clk);
        bus.res_valid = 1'b1;
        bus.res_data  = 32'hDEAD_DEAD;
        @(negedge clk);
        check("idle_res_ready", 32'(bus.res_ready), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        bus.res_valid = 1'b0;
        bus.res_data  = 32'h0;
        start_tile();
        capture(32'h0022_0021, 32'h0024_0023, 1);
        push_tile(32'h0022_0021, 32'h0024_0023);
        drain(16'hffff, 0, -1, 1'b1, 4);

        // Start and abort together in IDLE: abort wins.
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_busy", 32'(bus.busy), 32'd0);

        // Abort after two of four elements, then a clean tile.
        start_tile();
        capture(32'h0002_0001, 32'h0004_0003, 1);
        push_tile(32'h0002_0001, 32'h0004_0003);
        drain(16'hffff, 0, 2, 1'b0, 4);
        start_tile();
        capture(32'h0012_0011, 32'h0014_0013, 1);
        push_tile(32'h0012_0011, 32'h0014_0013);
        drain(16'hffff, 0, -1, 1'b0, 4);

        // Asynchronous reset after one captured row.
        start_tile();
        bus.res_valid = 1'b1;
        bus.res_data  = 32'h0032_0031;
        @(negedge clk);
        bus.res_valid = 1'b0;
        bus.res_data  = 32'h0;
        check("pre_rst_ready", 32'(bus.res_ready), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_res_ready", 32'(bus.res_ready), 32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_data", 32'(bus.out_data), 32'd0);
        check("arst_out_last", 32'(bus.out_last), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        start_tile();
        capture(32'h0042_0041, 32'h0044_0043, 1);
        push_tile(32'h0042_0041, 32'h0044_0043);
        drain(16'h0005, 4, -1, 1'b0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
